mulpop_sched: RTL and testbench
===============================

# mulpop_sched

Bus-controlled job scheduler for the 24×24 multiply / popcount datapath in the GPIO emulator. Buffers operand pairs written by the CPU in a small FIFO and feeds them one at a time to an iterative shift-add multiplier. Holds each 48-bit product and its ones-count until the CPU acknowledges it. Drives an 8-bit completed-job counter onto gpio_out.

## Interface
- FIFO_DEPTH, 4: operand-pair FIFO entries, power of 2, ≥2
- CW, $clog2(FIFO_DEPTH)+1: FIFO count width
- clk  in  1  system clock; all state on rising edge
- n_reset  in  1  reset, asynchronous, active-low
- saddress  in  16  CPU bus address
- srd  in  1  CPU read strobe, level, synchronous to clk
- swr  in  1  CPU write strobe, level, synchronous to clk
- sdata_in  in  32  CPU write data
- sdata_out  out  32  CPU read data, registered
- gpio_out  out  32  {24'h0, jobs_done[7:0]}

## Operation
- Strobes are edge-detected: a write or read acts once, on the first clk edge where swr/srd is high after being low. saddress and sdata_in are sampled on that edge.
- Register map, writes:
  - 0x37F: A1 ← sdata_in[23:0].
  - 0x380: pushes {A1, sdata_in[23:0]} into the FIFO. If the FIFO is full and no pop occurs that cycle, the pair is dropped and sticky ovf is set.
  - 0x3A0 CTRL: bit0 = en; bit1 = 1 clears ovf; bit2 = 1 flushes (FIFO emptied, running job aborted, done cleared, FSM → IDLE; en keeps the written bit0).
  - All other addresses: ignored.
- Register map, reads (return value registered into sdata_out):
  - 0x390: prod[31:0].
  - 0x394: {16'h0, prod[47:32]}.
  - 0x398: {26'h0, ones[5:0]}. This read also acknowledges the result: if done=1, done clears.
  - 0x3A0 STATUS: {0, cnt[CW-1:0] at bits 4+, ovf[3], done[2], busy[1], en[0]}.
  - Any other address: 0.
- FSM states and transitions:
  - IDLE: if en=1, FIFO non-empty and done=0, pop the head entry and load the multiplier → MUL.
  - MUL: 24 cycles, one multiplier bit per cycle (LSB first) → CNT.
  - CNT: popcount of the 48-bit product latched into ones; done←1; jobs_done++ (8-bit, wraps 255→0) → IDLE.
- done=1 blocks the next pop, so no result is overwritten before acknowledgement.
- en=0 pauses only at IDLE: a running job completes.
- busy = (state ≠ IDLE).
- Push and pop in the same cycle: both take effect and cnt is unchanged. A push to a full FIFO with a simultaneous pop is accepted.
- Flush has priority over a push in the same cycle; the pushed pair is dropped and ovf is unchanged.
- Reset, asynchronous, any state: FSM=IDLE; FIFO empty; A1, prod, ones, done, ovf, en, jobs_done = 0; sdata_out=0; gpio_out=0.

## Timing
- Write to 0x380 sampled at edge N: cnt reflects the entry at N+1. If the FSM is idle and enabled, the pop happens at N+1, busy=1 from N+2, and done=1 visible from N+27 (1 load + 24 MUL + 1 CNT + 1).
- Back-to-back jobs: the next pop occurs on the edge after done clears, so the minimum period is 26 cycles plus acknowledgement latency.
- sdata_out updates one edge after the read is sampled and holds until the next read.
- Read side effects (the done clear) take effect on the same edge that loads sdata_out.

## Structure
- Shared package mulpop_pkg:
  - address localparams ADDR_A1, ADDR_A2_PUSH, ADDR_RES_LO, ADDR_RES_HI, ADDR_ONES, ADDR_CSR
  - CTRL/STATUS bit indices
  - FSM state enum {IDLE, MUL, CNT}
- Sub-module shift_add_mul24:
  - start/done handshake
  - 24-cycle iterative multiplier with 48-bit accumulator
  - clears on start or flush
- FIFO and popcount stay inline.

## Test plan
- A1=3, push 5, en=1: done=1 at write+27 cycles; 0x390 reads 15, 0x394 reads 0, 0x398 reads 4; after the 0x398 read, done=0 and gpio_out=1.
- A1=0xFFFFFF, push 0xFFFFFF: 0x390 reads 0xFE000001, 0x394 reads 0x0000FFFF, 0x398 reads 24.
- en=0, push 5 pairs: STATUS cnt=4, ovf=1. Write CTRL=0x3: ovf=0, and jobs then run in FIFO order with each held until its 0x398 read.
- Push during MUL, then CTRL=0x5 (flush, en=1) at MUL cycle 10: busy=0 next cycle, cnt=0, done=0, gpio_out unchanged.
- Full FIFO with done pending: acknowledge via 0x398 and push in the same cycle; the pop and push both occur, cnt stays 4, ovf=0.
- 256 jobs completed: gpio_out wraps to 0. Assert n_reset mid-MUL: all outputs return to 0 asynchronously, and the FIFO is empty after release.

Source files
------------

// File: rtl/mulpop_pkg.sv
// rtl/mulpop_pkg.sv - shared addresses, register bit indices, FSM states and popcount helper
package mulpop_pkg;

    localparam logic [15:0] ADDR_A1      = 16'h037F;
    localparam logic [15:0] ADDR_A2_PUSH = 16'h0380;
    localparam logic [15:0] ADDR_RES_LO  = 16'h0390;
    localparam logic [15:0] ADDR_RES_HI  = 16'h0394;
    localparam logic [15:0] ADDR_ONES    = 16'h0398;
    localparam logic [15:0] ADDR_CSR     = 16'h03A0;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_OVF_CLR = 1;
    localparam int CTRL_FLUSH   = 2;

    localparam int STAT_EN      = 0;
    localparam int STAT_BUSY    = 1;
    localparam int STAT_DONE    = 2;
    localparam int STAT_OVF     = 3;
    localparam int STAT_CNT_LSB = 4;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        CNT
    } state_e;

    function automatic logic [5:0] popcount48(input logic [47:0] v);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < 48; i++) begin
            n = n + {5'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/shift_add_mul24.sv
// rtl/shift_add_mul24.sv - 24-cycle iterative shift-add multiplier, 24x24 -> 48
module shift_add_mul24 (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        start,
    input  logic        clear,
    input  logic [23:0] multiplicand,
    input  logic [23:0] multiplier,
    output logic        done,
    output logic [47:0] product
);

    logic [47:0] acc_q;
    logic [47:0] mcand_q;
    logic [23:0] mplier_q;
    logic [4:0]  step_q;
    logic        running_q;

    // done marks the cycle in which the last partial product is being added
    assign done    = running_q && (step_q == 5'd23);
    assign product = acc_q;

    // one multiplier bit per cycle, LSB first; clear aborts and zeroes the accumulator
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            step_q    <= '0;
            running_q <= 1'b0;
        end else if (clear) begin
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            step_q    <= '0;
            running_q <= 1'b0;
        end else if (start) begin
            acc_q     <= '0;
            mcand_q   <= {24'h0, multiplicand};
            mplier_q  <= multiplier;
            step_q    <= '0;
            running_q <= 1'b1;
        end else if (running_q) begin
            if (mplier_q[0]) begin
                acc_q <= acc_q + mcand_q;
            end
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            step_q   <= step_q + 5'd1;
            if (done) begin
                running_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mulpop_sched.sv
// rtl/mulpop_sched.sv - bus-controlled operand FIFO and multiply/popcount job scheduler
module mulpop_sched
    import mulpop_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic [15:0] saddress,
    input  logic        srd,
    input  logic        swr,
    input  logic [31:0] sdata_in,
    output logic [31:0] sdata_out,
    output logic [31:0] gpio_out
);

    localparam int AW = $clog2(FIFO_DEPTH);

    state_e          state_q, state_d;
    logic            swr_q, srd_q;
    logic            wr_fire, rd_fire;
    logic            wr_a1, wr_push, wr_csr, rd_ones, flush;
    logic            pop, mul_start, mul_done;
    logic            push_ok, ovf_set;
    logic            fifo_empty, fifo_full;
    logic [47:0]     fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   cnt_q;
    logic [47:0]     head;
    logic [47:0]     mul_product;
    logic [23:0]     a1_q;
    logic [47:0]     prod_q;
    logic [5:0]      ones_q;
    logic            done_q, ovf_q, en_q;
    logic [7:0]      jobs_done_q;
    logic [31:0]     status;
    logic            unused_ok;

    assign unused_ok = ^sdata_in[31:24];

    assign wr_fire = swr && !swr_q;
    assign rd_fire = srd && !srd_q;
    assign wr_a1   = wr_fire && (saddress == ADDR_A1);
    assign wr_push = wr_fire && (saddress == ADDR_A2_PUSH);
    assign wr_csr  = wr_fire && (saddress == ADDR_CSR);
    assign rd_ones = rd_fire && (saddress == ADDR_ONES);
    assign flush   = wr_csr && sdata_in[CTRL_FLUSH];

    assign fifo_empty = (cnt_q == '0);
    assign fifo_full  = (cnt_q == CW'(FIFO_DEPTH));
    assign head       = fifo_mem[rd_ptr_q];

    // a pop frees a slot in the same cycle, so a push to a full FIFO is then accepted
    assign push_ok = wr_push && !flush && (!fifo_full || pop);
    assign ovf_set = wr_push && !flush && fifo_full && !pop;

    assign gpio_out = {24'h0, jobs_done_q};

    // strobe history for rising-edge detection
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            swr_q <= 1'b0;
            srd_q <= 1'b0;
        end else begin
            swr_q <= swr;
            srd_q <= srd;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next state and pop/start; a pending result (done) holds off the next pop
    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        mul_start = 1'b0;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (en_q && !fifo_empty && !done_q) begin
                        pop       = 1'b1;
                        mul_start = 1'b1;
                        state_d   = MUL;
                    end
                end
                MUL: begin
                    if (mul_done) begin
                        state_d = CNT;
                    end
                end
                CNT: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // FIFO storage; contents need no reset since the pointers define validity
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_q] <= {a1_q, sdata_in[23:0]};
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push_ok, pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    shift_add_mul24 u_mul (
        .clk          (clk),
        .n_reset      (n_reset),
        .start        (mul_start),
        .clear        (flush),
        .multiplicand (head[47:24]),
        .multiplier   (head[23:0]),
        .done         (mul_done),
        .product      (mul_product)
    );

    // control/status flags, operand A1 and result capture in CNT
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            a1_q        <= '0;
            en_q        <= 1'b0;
            ovf_q       <= 1'b0;
            done_q      <= 1'b0;
            prod_q      <= '0;
            ones_q      <= '0;
            jobs_done_q <= '0;
        end else begin
            if (wr_a1) begin
                a1_q <= sdata_in[23:0];
            end
            if (wr_csr) begin
                en_q <= sdata_in[CTRL_EN];
            end
            if (wr_csr && sdata_in[CTRL_OVF_CLR]) begin
                ovf_q <= 1'b0;
            end else if (ovf_set) begin
                ovf_q <= 1'b1;
            end
            if (flush) begin
                done_q <= 1'b0;
            end else if (state_q == CNT) begin
                done_q      <= 1'b1;
                prod_q      <= mul_product;
                ones_q      <= popcount48(mul_product);
                jobs_done_q <= jobs_done_q + 8'd1;
            end else if (rd_ones && done_q) begin
                done_q <= 1'b0;
            end
        end
    end

    // STATUS word assembled from the live flags
    always_comb begin
        status                         = '0;
        status[STAT_EN]                = en_q;
        status[STAT_BUSY]              = (state_q != IDLE);
        status[STAT_DONE]              = done_q;
        status[STAT_OVF]               = ovf_q;
        status[STAT_CNT_LSB +: CW]     = cnt_q;
    end

    // registered read data, held until the next read
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            sdata_out <= '0;
        end else if (rd_fire) begin
            case (saddress)
                ADDR_RES_LO: sdata_out <= prod_q[31:0];
                ADDR_RES_HI: sdata_out <= {16'h0, prod_q[47:32]};
                ADDR_ONES:   sdata_out <= {26'h0, ones_q};
                ADDR_CSR:    sdata_out <= status;
                default:     sdata_out <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mulpop_sched.sv
// tb/tb_mulpop_sched.sv - self-checking bench for mulpop_sched with a queue-based job model
module tb_mulpop_sched;

    localparam logic [15:0] A_A1   = 16'h037F;
    localparam logic [15:0] A_PUSH = 16'h0380;
    localparam logic [15:0] A_LO   = 16'h0390;
    localparam logic [15:0] A_HI   = 16'h0394;
    localparam logic [15:0] A_ONES = 16'h0398;
    localparam logic [15:0] A_CSR  = 16'h03A0;

    logic        clk = 1'b0;
    logic        n_reset = 1'b0;
    logic [15:0] saddress = '0;
    logic        srd = 1'b0;
    logic        swr = 1'b0;
    logic [31:0] sdata_in = '0;
    logic [31:0] sdata_out;
    logic [31:0] gpio_out;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int jobs_m = 0;
    logic [23:0] a1_m = '0;
    logic [47:0] model_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mulpop_sched dut (
        .clk       (clk),
        .n_reset   (n_reset),
        .saddress  (saddress),
        .srd       (srd),
        .swr       (swr),
        .sdata_in  (sdata_in),
        .sdata_out (sdata_out),
        .gpio_out  (gpio_out)
    );

    initial begin
        #900000;
        $display("FAIL watchdog simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic write_at(input logic [15:0] a, input logic [31:0] d, input int target);
        while (cyc < target - 1) begin
            @(posedge clk);
            #1;
        end
        saddress = a;
        sdata_in = d;
        swr = 1'b1;
        @(posedge clk);
        #1;
        swr = 1'b0;
    endtask

    task automatic read_at(input logic [15:0] a, input int target, output logic [31:0] d);
        while (cyc < target - 1) begin
            @(posedge clk);
            #1;
        end
        saddress = a;
        srd = 1'b1;
        @(posedge clk);
        #1;
        srd = 1'b0;
        d = sdata_out;
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
        write_at(a, d, cyc + 2);
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [31:0] d);
        read_at(a, cyc + 2, d);
    endtask

    task automatic push_pair(input logic [23:0] a, input logic [23:0] b);
        bus_write(A_A1, {8'h0, a});
        a1_m = a;
        bus_write(A_PUSH, {8'h0, b});
    endtask

    task automatic wait_done(input string tag);
        logic [31:0] st;
        bit seen;
        seen = 1'b0;
        st = '0;
        for (int i = 0; i < 40; i++) begin
            bus_read(A_CSR, st);
            if (st[2]) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s done_timeout status=0x%08h required done=1", tag, st);
        end
    endtask

    task automatic check_ack(input string tag, output int k);
        logic [31:0] d;
        logic [47:0] pr;
        logic [63:0] p;
        if (model_q.size() > 0) pr = model_q.pop_front();
        else pr = '0;
        p = {40'd0, pr[47:24]} * {40'd0, pr[23:0]};
        bus_read(A_LO, d);
        checks++;
        if (d !== p[31:0]) begin
            failures++;
            $display("FAIL %s res_lo got=0x%08h required=0x%08h", tag, d, p[31:0]);
        end
        bus_read(A_HI, d);
        checks++;
        if (d !== {16'h0, p[47:32]}) begin
            failures++;
            $display("FAIL %s res_hi got=0x%08h required=0x%08h", tag, d, {16'h0, p[47:32]});
        end
        bus_read(A_ONES, d);
        k = cyc;
        checks++;
        if (d !== 32'($countones(p[47:0]))) begin
            failures++;
            $display("FAIL %s ones got=%0d required=%0d", tag, d, $countones(p[47:0]));
        end
        jobs_m = (jobs_m + 1) % 256;
        checks++;
        if (gpio_out !== 32'(jobs_m)) begin
            failures++;
            $display("FAIL %s gpio_out got=0x%08h required=0x%08h", tag, gpio_out, 32'(jobs_m));
        end
    endtask

    task automatic expect_status(input string tag, input int target, input logic [31:0] exp);
        logic [31:0] d;
        read_at(A_CSR, target, d);
        checks++;
        if (d !== exp) begin
            failures++;
            $display("FAIL %s status got=0x%08h required=0x%08h", tag, d, exp);
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        n_reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (sdata_out !== 32'h0) begin
            failures++;
            $display("FAIL reset_sdata_out got=0x%08h required=0", sdata_out);
        end
        checks++;
        if (gpio_out !== 32'h0) begin
            failures++;
            $display("FAIL reset_gpio_out got=0x%08h required=0", gpio_out);
        end
        n_reset = 1'b1;
        @(posedge clk);
        #1;
        model_q.delete();
        jobs_m = 0;
        expect_status("reset_status", cyc + 2, 32'h0);
        bus_read(A_LO, d);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL reset_res_lo got=0x%08h required=0", d);
        end
        bus_read(A_ONES, d);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL reset_ones got=0x%08h required=0", d);
        end
    endtask

    task automatic test_basic();
        int n, k;
        bus_write(A_CSR, 32'h1);
        push_pair(24'd3, 24'd5);
        n = cyc;
        model_q.push_back({24'd3, 24'd5});
        expect_status("basic_cnt_n1", n + 1, 32'h11);
        expect_status("basic_busy_n3", n + 3, 32'h03);
        expect_status("basic_notdone_n25", n + 25, 32'h03);
        expect_status("basic_done_n27", n + 27, 32'h05);
        check_ack("basic", k);
        expect_status("basic_acked", cyc + 2, 32'h01);
    endtask

    task automatic test_all_ones();
        int n, k;
        push_pair(24'hFFFFFF, 24'hFFFFFF);
        n = cyc;
        model_q.push_back({24'hFFFFFF, 24'hFFFFFF});
        expect_status("ones_notdone_n26", n + 26, 32'h03);
        wait_done("all_ones");
        check_ack("all_ones", k);
    endtask

    task automatic test_random_jobs();
        int k;
        logic [23:0] a, b;
        for (int i = 0; i < 6; i++) begin
            a = 24'($urandom);
            b = (i == 0) ? 24'd0 : 24'($urandom);
            push_pair(a, b);
            model_q.push_back({a, b});
            wait_done("random");
            check_ack("random", k);
        end
    endtask

    task automatic test_overflow_order();
        int k;
        logic [23:0] a, b;
        bus_write(A_CSR, 32'h0);
        for (int i = 0; i < 5; i++) begin
            a = 24'($urandom);
            b = 24'($urandom);
            push_pair(a, b);
            if (model_q.size() < 4) model_q.push_back({a, b});
        end
        expect_status("ovf_full", cyc + 2, 32'h48);
        bus_write(A_CSR, 32'h3);
        expect_status("ovf_cleared_running", cyc + 2, 32'h33);
        for (int i = 0; i < 4; i++) begin
            wait_done("order");
            check_ack("order", k);
        end
        expect_status("order_drained", cyc + 2, 32'h01);
    endtask

    task automatic test_flush();
        int n;
        logic [23:0] a, b;
        a = 24'($urandom) | 24'h1;
        b = 24'($urandom) | 24'h1;
        push_pair(a, b);
        n = cyc;
        write_at(A_PUSH, {8'h0, 24'($urandom)}, n + 3);
        write_at(A_CSR, 32'h5, n + 11);
        model_q.delete();
        expect_status("flush_idle", n + 12, 32'h01);
        checks++;
        if (gpio_out !== 32'(jobs_m)) begin
            failures++;
            $display("FAIL flush_gpio got=0x%08h required=0x%08h", gpio_out, 32'(jobs_m));
        end
        repeat (40) @(posedge clk);
        #1;
        expect_status("flush_stays_idle", cyc + 2, 32'h01);
    endtask

    task automatic test_full_ack();
        int k;
        logic [23:0] a, b;
        a = 24'($urandom);
        b = 24'($urandom);
        push_pair(a, b);
        model_q.push_back({a, b});
        wait_done("full_first");
        for (int i = 0; i < 4; i++) begin
            a = 24'($urandom);
            b = 24'($urandom);
            push_pair(a, b);
            model_q.push_back({a, b});
        end
        expect_status("full_pending", cyc + 2, 32'h45);
        a = 24'($urandom);
        bus_write(A_A1, {8'h0, a});
        a1_m = a;
        check_ack("full_first", k);
        b = 24'($urandom);
        write_at(A_PUSH, {8'h0, b}, k + 1);
        model_q.push_back({a, b});
        expect_status("full_push_pop", k + 3, 32'h43);
        for (int i = 0; i < 4; i++) begin
            wait_done("full_drain");
            check_ack("full_drain", k);
        end
    endtask

    task automatic test_wrap();
        int k;
        logic [23:0] a, b;
        n_reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_reset = 1'b1;
        model_q.delete();
        jobs_m = 0;
        bus_write(A_CSR, 32'h1);
        a = 24'($urandom);
        bus_write(A_A1, {8'h0, a});
        for (int j = 0; j < 256; j++) begin
            b = 24'($urandom);
            bus_write(A_PUSH, {8'h0, b});
            model_q.push_back({a, b});
            wait_done("wrap");
            check_ack("wrap", k);
        end
        checks++;
        if (gpio_out !== 32'h0) begin
            failures++;
            $display("FAIL wrap_gpio got=0x%08h required=0", gpio_out);
        end
    endtask

    task automatic test_async_reset();
        int n, k;
        logic [23:0] a, b;
        a = 24'($urandom) | 24'h1;
        b = 24'($urandom) | 24'h1;
        push_pair(a, b);
        model_q.push_back({a, b});
        wait_done("areset_pre");
        check_ack("areset_pre", k);
        bus_write(A_PUSH, {8'h0, 24'($urandom)});
        n = cyc;
        bus_write(A_PUSH, {8'h0, 24'($urandom)});
        while (cyc < n + 8) begin
            @(posedge clk);
            #1;
        end
        #3;
        n_reset = 1'b0;
        #1;
        checks++;
        if (sdata_out !== 32'h0) begin
            failures++;
            $display("FAIL areset_sdata_out got=0x%08h required=0", sdata_out);
        end
        checks++;
        if (gpio_out !== 32'h0) begin
            failures++;
            $display("FAIL areset_gpio_out got=0x%08h required=0", gpio_out);
        end
        @(posedge clk);
        #1;
        n_reset = 1'b1;
        model_q.delete();
        jobs_m = 0;
        expect_status("areset_empty", cyc + 2, 32'h0);
        bus_write(A_CSR, 32'h1);
        repeat (30) @(posedge clk);
        #1;
        expect_status("areset_no_job", cyc + 2, 32'h01);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_all_ones();
        test_random_jobs();
        test_overflow_order();
        test_flush();
        test_full_ack();
        test_wrap();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
